// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states and default operand width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// One-bit full subtractor cell: difference and borrow-out of a - b - bin.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor with valid/ready handshakes: one bit per cycle, LSB first.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, diff_shift;
  logic [CW-1:0]    cnt;
  logic             br, br_next, d, last;

  fullsubtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d),
    .bout (br_next)
  );

  assign last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // New difference bit enters at the MSB so the result is aligned after WIDTH shifts.
  always_comb begin
    diff_shift             = diff >> 1;
    diff_shift[WIDTH-1]    = d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= a;
            b_sh <= b;
            br   <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          diff <= diff_shift;
          // Counter holds on the final bit so it never wraps inside a job.
          if (last) begin
            bout <= br_next;
            ovf  <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, bout, ovf;
  logic [W-1:0] a, b, diff;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  // Returns {ovf, bout, diff} computed with plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int ux, uy, sx, sy, r, s;
    logic [W+1:0] res;
    ux = int'(x);
    uy = int'(y);
    sx = x[W-1] ? ux - (1 << W) : ux;
    sy = y[W-1] ? uy - (1 << W) : uy;
    r  = ux - uy;
    s  = sx - sy;
    res[W-1:0] = r[W-1:0];
    res[W]     = (r < 0);
    res[W+1]   = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
    return res;
  endfunction

  // Called at the negedge after the accepting edge; counts edges until out_valid.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 4*W) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic start_job(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic run_check(input string name, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    logic [W+1:0] exp;
    exp = model(x, y);
    start_job(x, y);
    wait_out(lat);
    checks++;
    if (lat != W) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, lat, W);
    end
    checks++;
    if ({ovf, bout, diff} !== exp) begin
      errors++;
      $display("FAIL %s result: diff=%h bout=%b ovf=%b required diff=%h bout=%b ovf=%b",
               name, diff, bout, ovf, exp[W-1:0], exp[W], exp[W+1]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({diff, bout, ovf, out_valid, in_ready} !== {{W{1'b0}}, 4'b0001}) begin
      errors++;
      $display("FAIL reset_state: diff=%h bout=%b ovf=%b out_valid=%b in_ready=%b required 0/0/0/0/1",
               diff, bout, ovf, out_valid, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    run_check("sub_05_03", 8'h05, 8'h03);
    run_check("sub_03_05", 8'h03, 8'h05);
    run_check("sub_00_00", 8'h00, 8'h00);
    run_check("sub_80_01", 8'h80, 8'h01);
    run_check("sub_7f_ff", 8'h7F, 8'hFF);
    run_check("sub_ff_00", 8'hFF, 8'h00);
    for (int i = 0; i < 6; i++) run_check("sub_rand", W'($urandom), W'($urandom));
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W+1:0] exp, exp2;
    logic [W-1:0] nx, ny;
    exp = model(8'h3C, 8'h5A);
    start_job(8'h3C, 8'h5A);
    wait_out(lat);
    checks++;
    if (lat != W) begin
      errors++;
      $display("FAIL bp_latency: got %0d required %0d", lat, W);
    end
    nx = W'($urandom);
    ny = W'($urandom);
    exp2 = model(nx, ny);
    a = nx;
    b = ny;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, bout, diff} !== exp) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d out_valid=%b in_ready=%b diff=%h bout=%b ovf=%b required 1/0/%h/%b/%b",
                 i, out_valid, in_ready, diff, bout, ovf, exp[W-1:0], exp[W], exp[W+1]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    checks++;
    if (lat != W || {ovf, bout, diff} !== exp2) begin
      errors++;
      $display("FAIL bp_next_job: lat=%0d diff=%h bout=%b ovf=%b required %0d/%h/%b/%b",
               lat, diff, bout, ovf, W, exp2[W-1:0], exp2[W], exp2[W+1]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    start_job(8'hAA, 8'h55);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({diff, bout, ovf, out_valid, in_ready} !== {{W{1'b0}}, 4'b0001}) begin
      errors++;
      $display("FAIL abort_state: diff=%h bout=%b ovf=%b out_valid=%b in_ready=%b required 0/0/0/0/1",
               diff, bout, ovf, out_valid, in_ready);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    out_ready = 1'b1;
    repeat (2*W) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    out_ready = 1'b0;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_result: out_valid rose=%b required 0", seen);
    end
    run_check("after_abort", 8'h10, 8'h01);
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] pend[$];
    logic [2*W-1:0] pr;
    logic [W+1:0]   exp;
    int acc, res, cyc, last_acc;
    acc = 0;
    res = 0;
    cyc = 0;
    last_acc = -1;
    a = W'($urandom);
    b = W'($urandom);
    in_valid = 1'b1;
    out_ready = 1'b1;
    while ((acc < 256 || res < 256) && cyc < 256*(W+2) + 100) begin
      if (acc >= 256) in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        res++;
        checks++;
        if (pend.size() == 0) begin
          errors++;
          $display("FAIL b2b_spurious: out_valid=1 with no job pending");
        end else begin
          pr  = pend.pop_front();
          exp = model(pr[2*W-1:W], pr[W-1:0]);
          if ({ovf, bout, diff} !== exp) begin
            errors++;
            $display("FAIL b2b_result: a=%h b=%h diff=%h bout=%b ovf=%b required %h/%b/%b",
                     pr[2*W-1:W], pr[W-1:0], diff, bout, ovf, exp[W-1:0], exp[W], exp[W+1]);
          end
        end
      end
      if (in_ready === 1'b1 && in_valid) begin
        pend.push_back({a, b});
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != W + 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles required %0d", cyc - last_acc, W + 2);
          end
        end
        last_acc = cyc;
        acc++;
      end else if (in_ready !== 1'b1) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (acc != 256 || res != 256) begin
      errors++;
      $display("FAIL b2b_count: accepted=%0d results=%0d required 256/256", acc, res);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair on a/b is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-006 The block SHALL have port a, input, WIDTH bits: minuend.
REQ-007 The block SHALL have port b, input, WIDTH bits: subtrahend.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result outputs are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-010 The block SHALL have port diff, output, WIDTH bits: a - b modulo 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1 bit: final borrow; 1 iff a < b unsigned.
REQ-012 The block SHALL have port ovf, output, 1 bit: signed (two's-complement) overflow of a - b.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 In IDLE, on in_valid=1, the block SHALL latch a and b into shift registers, clear the borrow flop and bit counter, and enter RUN.
REQ-016 Each RUN cycle SHALL process one bit, LSB first: d = a_i ^ b_i ^ br and br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
- d shifts into diff from the MSB side.
- The counter increments.
REQ-017 The cycle that processes bit WIDTH-1 SHALL also:
- register bout = br';
- register ovf = (a_msb ^ b_msb) & (a_msb ^ d_msb);
- enter DONE.
REQ-018 Latency SHALL be exactly WIDTH cycles: out_valid first samples high WIDTH rising edges after the accepting edge.
REQ-019 In DONE, diff, bout and ovf SHALL hold stable until out_valid & out_ready; on that edge the FSM SHALL return to IDLE.
REQ-020 out_ready SHALL be ignored outside DONE, and in_valid outside IDLE. There is no overlap: the earliest next acceptance is one cycle after the handshake, so the minimum period is WIDTH+2 cycles.
REQ-021 Inputs a and b SHALL be sampled only on the accepting edge; changes during RUN or DONE have no effect.
REQ-022 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within a job.

Reset
REQ-023 While rst_n=0 at a rising edge, the block SHALL force:
- state = IDLE;
- counter = 0, borrow = 0;
- diff = 0, bout = 0, ovf = 0;
- out_valid = 0, in_ready = 1 from the next cycle.
REQ-024 Reset asserted mid-RUN or in DONE SHALL abort the job with no result emitted. Reset has priority over every handshake.

Structure
REQ-025 A shared package SHALL hold the state enumeration (IDLE/RUN/DONE) and the default-width constant (8).
REQ-026 The one-bit borrow cell SHALL be a sub-module fullsubtractor (inputs a, b, bin; outputs d, bout), instantiated once and reused each cycle.

Verification
REQ-027 a=0x05, b=0x03 -> diff=0x02, bout=0, ovf=0, with out_valid rising 8 cycles after acceptance.
REQ-028 a=0x03, b=0x05 -> diff=0xFE, bout=1, ovf=0; a=0x00, b=0x00 -> diff=0x00, bout=0, ovf=0.
REQ-029 a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
REQ-030 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, and a new in_valid is not accepted until after the handshake.
REQ-031 Assert rst_n=0 at RUN bit 3 of a=0xAA, b=0x55 -> all outputs 0 and in_ready=1 next cycle; a following job a=0x10, b=0x01 -> diff=0x0F.
REQ-032 Back-to-back: 256 random pairs with out_ready=1 -> each result matches the reference a-b, with acceptance spacing of exactly WIDTH+2 cycles.
